buf_rd_port_arbiter: RTL and testbench
======================================

Name: buf_rd_port_arbiter

Overview:
Shares one on-chip feature-buffer read port (11-bit address, 512-bit data, fixed read latency) among NUM_REQ requesters, such as the save, aggregate and matmul engines. It issues at most one read per cycle using sticky round-robin arbitration. Each issued read is tagged with its requester ID so that returned data is steered back to the requester that asked for it. One instance sits in front of each buffer bank (1_A, 1_B, 2_A, 2_B).

Parameters:
NUM_REQ, 3, number of requesters (2..8)
ADDR_WIDTH, 11, buffer word address width
DATA_WIDTH, 512, buffer data width
RD_LATENCY, 2, cycles from buf_avalid high to buf_valid high (1..8)
MAX_HOLD, 16, max consecutive grants to one requester while others wait (1..255)

Ports:
aclk  in  1  clock
areset  in  1  asynchronous active-high reset
req_avalid  in  NUM_REQ  per-requester read request
req_addr  in  NUM_REQ*ADDR_WIDTH  packed addresses; requester i uses [i*ADDR_WIDTH +: ADDR_WIDTH]
req_aready  out  NUM_REQ  one-hot grant, combinational, same cycle as the request
resp_valid  out  NUM_REQ  one-hot read-data valid
resp_data  out  DATA_WIDTH  read data, broadcast to all requesters
buf_avalid  out  1  buffer read address valid
buf_addr  out  ADDR_WIDTH  buffer read address
buf_valid  in  1  buffer read data valid
buf_data  in  DATA_WIDTH  buffer read data
busy  out  1  reads in flight or a request pending
err_unexpected  out  1  sticky; buf_valid seen with no read in flight

Behaviour:
- Reset values:
  - req_aready, resp_valid, buf_avalid, busy, err_unexpected = 0.
  - buf_addr, resp_data = 0.
  - Owner = requester 0; hold counter = 0; tag pipeline empty.
- Clock: everything is on aclk. areset clears all state immediately, including reads in flight.
- Handshake: a request is accepted in any cycle where req_avalid[i] && req_aready[i]. Requesters hold their address until accepted. There is no backpressure on responses.
- Arbitration (combinational over current requests, registered owner/hold state):
  - If the owner is requesting and hold_cnt < MAX_HOLD, or no other requester is requesting: grant the owner.
  - Otherwise: grant the first requesting index after the owner, in circular order from owner+1 through NUM_REQ-1 and then 0.
  - On a grant to a new requester: owner <= granted index, hold_cnt <= 1.
  - On a grant to the same owner: hold_cnt <= hold_cnt+1, saturating at MAX_HOLD.
  - No grant: owner is unchanged and hold_cnt <= 0.
- Issue: the cycle after acceptance, buf_avalid = 1 and buf_addr = the accepted address. Otherwise buf_avalid = 0 and buf_addr holds its last value.
- Tag pipeline:
  - RD_LATENCY stages of {valid, id}, shifted every cycle and loaded from the issue stage.
  - The stage aligned with buf_valid identifies the destination requester.
- Response:
  - Registered. One cycle after buf_valid with a matching valid tag: resp_valid[id] = 1 and resp_data = buf_data.
  - Total latency from accept to resp_valid = RD_LATENCY + 2 cycles.
  - Responses are returned in issue order.
- Error: if buf_valid arrives while the aligned tag is invalid, err_unexpected <= 1 (sticky until reset) and no resp_valid is raised.
- A valid aligned tag without buf_valid is dropped silently; the buffer contract forbids this case.
- busy = |req_avalid OR issue stage valid OR any tag stage valid OR any resp_valid.
- Throughput: one read per cycle, back-to-back, including across a grant switch (no bubble).
- Simultaneous events: a new grant and a response in the same cycle are independent. A requester may be granted while receiving an earlier response.

Optional Feature:
ARB_STATS_EN
- Defined: adds output stat_grant_cnt (NUM_REQ*32 bits) and input stat_clr (1 bit).
  - Counter i increments on every accepted request from requester i and wraps at 2^32.
  - stat_clr synchronously zeroes all counters; if it coincides with a grant, the counter reads 0 after that cycle.
  - All counters reset to 0.
- Undefined: these ports and counters do not exist; arbitration and timing are identical.

Test Plan:
- Single request: req_avalid[1]=1, addr 0x055 for 1 cycle → req_aready[1] same cycle; buf_avalid/buf_addr=0x055 next cycle; with the model returning data 0xAB.. after 2 cycles, resp_valid[1]=1 with that data 4 cycles after accept.
- Sticky hold: req 0 and req 2 both continuously requesting, MAX_HOLD=16 → 16 grants to req 0, then 16 to req 2, alternating, with buf_avalid high every cycle.
- Round-robin wrap: owner=2, reqs 0 and 1 request → grant order 0, then 1; req 2 gets no grant until it re-requests.
- Interleaved return: alternating grants 0,1,0,1 at addresses 0..3 → resp_valid sequence 0,1,0,1 in issue order, each carrying data for its own address.
- Reset mid-flight: assert areset while 2 reads are in flight → all outputs 0 immediately. A stray buf_valid after release → err_unexpected=1 and no resp_valid.
- ARB_STATS_EN: 5 grants to req 0 and 3 to req 2 → counts 5/0/3; stat_clr pulse → all counts 0.

Source files
------------

// File: rtl/buf_rd_port_arbiter.sv
// Round-robin read-port arbiter for one feature-buffer bank, with tag-steered responses.
// Optional per-requester grant counters are enabled by defining ARB_STATS_EN.
module buf_rd_port_arbiter #(
  parameter int NUM_REQ    = 3,
  parameter int ADDR_WIDTH = 11,
  parameter int DATA_WIDTH = 512,
  parameter int RD_LATENCY = 2,
  parameter int MAX_HOLD   = 16
) (
  input  logic                          aclk,
  input  logic                          areset,
  input  logic [NUM_REQ-1:0]            req_avalid,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  output logic [NUM_REQ-1:0]            req_aready,
  output logic [NUM_REQ-1:0]            resp_valid,
  output logic [DATA_WIDTH-1:0]         resp_data,
  output logic                          buf_avalid,
  output logic [ADDR_WIDTH-1:0]         buf_addr,
  input  logic                          buf_valid,
  input  logic [DATA_WIDTH-1:0]         buf_data,
  output logic                          busy,
  output logic                          err_unexpected
`ifdef ARB_STATS_EN
  ,
  input  logic                          stat_clr,
  output logic [NUM_REQ*32-1:0]         stat_grant_cnt
`endif
);

  localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int HW  = $clog2(MAX_HOLD + 1);
  localparam logic [HW-1:0] HOLD_MAX = HW'(MAX_HOLD);

  logic [IDW-1:0]        owner_q, owner_d;
  logic [HW-1:0]         hold_q, hold_d;
  logic                  iss_v_q;
  logic [IDW-1:0]        iss_id_q;
  logic [ADDR_WIDTH-1:0] buf_addr_q;
  logic [RD_LATENCY-1:0] tag_v_q;
  logic [IDW-1:0]        tag_id_q [RD_LATENCY];
  logic [NUM_REQ-1:0]    resp_valid_q;
  logic [DATA_WIDTH-1:0] resp_data_q;
  logic                  err_q;

  logic [NUM_REQ-1:0]    owner_oh;
  logic                  owner_req;
  logic                  others_req;
  logic                  rr_found;
  logic [IDW-1:0]        rr_idx;
  logic                  gnt_any;
  logic [IDW-1:0]        gnt_idx;
  logic [NUM_REQ-1:0]    gnt_oh;
  logic [ADDR_WIDTH-1:0] gnt_addr;

  assign owner_oh   = NUM_REQ'(1) << owner_q;
  assign owner_req  = req_avalid[owner_q];
  assign others_req = |(req_avalid & ~owner_oh);

  // First requester after the owner, wrapping through index 0.
  always_comb begin
    rr_found = 1'b0;
    rr_idx   = '0;
    for (int k = 1; k < NUM_REQ; k++) begin
      if (!rr_found && req_avalid[(int'(owner_q) + k) % NUM_REQ]) begin
        rr_found = 1'b1;
        rr_idx   = IDW'((int'(owner_q) + k) % NUM_REQ);
      end
    end
  end

  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = owner_q;
    if ((owner_req && (hold_q < HOLD_MAX)) || !others_req) begin
      gnt_any = owner_req;
      gnt_idx = owner_q;
    end else begin
      gnt_any = rr_found;
      gnt_idx = rr_idx;
    end
  end

  assign gnt_oh   = gnt_any ? (NUM_REQ'(1) << gnt_idx) : '0;
  assign gnt_addr = req_addr[int'(gnt_idx)*ADDR_WIDTH +: ADDR_WIDTH];

  always_comb begin
    owner_d = owner_q;
    hold_d  = '0;
    if (gnt_any) begin
      if (gnt_idx != owner_q) begin
        owner_d = gnt_idx;
        hold_d  = HW'(1);
      end else begin
        hold_d = (hold_q == HOLD_MAX) ? hold_q : hold_q + 1'b1;
      end
    end
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      owner_q      <= '0;
      hold_q       <= '0;
      iss_v_q      <= 1'b0;
      iss_id_q     <= '0;
      buf_addr_q   <= '0;
      tag_v_q      <= '0;
      for (int s = 0; s < RD_LATENCY; s++) tag_id_q[s] <= '0;
      resp_valid_q <= '0;
      resp_data_q  <= '0;
      err_q        <= 1'b0;
    end else begin
      owner_q  <= owner_d;
      hold_q   <= hold_d;
      iss_v_q  <= gnt_any;
      iss_id_q <= gnt_idx;
      if (gnt_any) buf_addr_q <= gnt_addr;

      tag_v_q[0]  <= iss_v_q;
      tag_id_q[0] <= iss_id_q;
      for (int s = 1; s < RD_LATENCY; s++) begin
        tag_v_q[s]  <= tag_v_q[s-1];
        tag_id_q[s] <= tag_id_q[s-1];
      end

      // The last tag stage lines up with the buffer's data return.
      resp_valid_q <= '0;
      if (buf_valid) begin
        if (tag_v_q[RD_LATENCY-1]) begin
          resp_valid_q <= NUM_REQ'(1) << tag_id_q[RD_LATENCY-1];
          resp_data_q  <= buf_data;
        end else begin
          err_q <= 1'b1;
        end
      end
    end
  end

  assign req_aready     = areset ? '0 : gnt_oh;
  assign buf_avalid     = iss_v_q;
  assign buf_addr       = buf_addr_q;
  assign resp_valid     = resp_valid_q;
  assign resp_data      = resp_data_q;
  assign err_unexpected = err_q;
  assign busy           = !areset && ((|req_avalid) || iss_v_q || (|tag_v_q) || (|resp_valid_q));

`ifdef ARB_STATS_EN
  logic [31:0] cnt_q [NUM_REQ];

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      for (int i = 0; i < NUM_REQ; i++) cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (stat_clr)       cnt_q[i] <= '0;
        else if (gnt_oh[i]) cnt_q[i] <= cnt_q[i] + 32'd1;
      end
    end
  end

  always_comb begin
    stat_grant_cnt = '0;
    for (int i = 0; i < NUM_REQ; i++) stat_grant_cnt[i*32 +: 32] = cnt_q[i];
  end
`endif

endmodule

// File: tb/tb_buf_rd_port_arbiter.sv
// Directed bench for buf_rd_port_arbiter with a fixed-latency buffer model.
module tb_buf_rd_port_arbiter;

  localparam logic [10:0] J0 = 11'h6A6;
  localparam logic [10:0] J1 = 11'h5B5;
  localparam logic [10:0] J2 = 11'h7C7;

  logic         aclk = 1'b0;
  logic         areset = 1'b1;
  logic [2:0]   req_avalid = '0;
  logic [32:0]  req_addr = '0;
  logic [2:0]   req_aready;
  logic [2:0]   resp_valid;
  logic [511:0] resp_data;
  logic         buf_avalid;
  logic [10:0]  buf_addr;
  logic         buf_valid;
  logic [511:0] buf_data;
  logic         busy;
  logic         err_unexpected;
  logic         stray = 1'b0;
`ifdef ARB_STATS_EN
  logic         stat_clr = 1'b0;
  logic [95:0]  stat_grant_cnt;
`endif

  int total = 0;
  int bad = 0;

  buf_rd_port_arbiter dut (
    .aclk(aclk), .areset(areset),
    .req_avalid(req_avalid), .req_addr(req_addr), .req_aready(req_aready),
    .resp_valid(resp_valid), .resp_data(resp_data),
    .buf_avalid(buf_avalid), .buf_addr(buf_addr),
    .buf_valid(buf_valid), .buf_data(buf_data),
    .busy(busy), .err_unexpected(err_unexpected)
`ifdef ARB_STATS_EN
    , .stat_clr(stat_clr), .stat_grant_cnt(stat_grant_cnt)
`endif
  );

  always #5 aclk = ~aclk;

  function automatic logic [511:0] dfun(input logic [10:0] a);
    return {16{8'hAB, 13'h0, a}};
  endfunction

  // Buffer model: data returns two cycles after the address is presented.
  logic        p1_v, p2_v;
  logic [10:0] p1_a, p2_a;
  always @(posedge aclk or posedge areset) begin
    if (areset) begin
      p1_v <= 1'b0; p2_v <= 1'b0; p1_a <= '0; p2_a <= '0;
    end else begin
      p1_v <= buf_avalid; p1_a <= buf_addr;
      p2_v <= p1_v;       p2_a <= p1_a;
    end
  end
  assign buf_valid = p2_v | stray;
  assign buf_data  = p2_v ? dfun(p2_a) : '0;

  task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic [2:0] r, input logic [10:0] x0, input logic [10:0] x1, input logic [10:0] x2);
    @(negedge aclk);
    req_avalid = r;
    req_addr   = {x2, x1, x0};
    #1;
  endtask

  task automatic do_reset();
    @(negedge aclk);
    req_avalid = '0;
    areset = 1'b1;
    @(negedge aclk);
    areset = 1'b0;
  endtask

  typedef struct {
    logic [2:0]  req;
    logic [10:0] a0, a1, a2;
    logic [2:0]  rdy;
    logic        bav;
    logic [10:0] baddr;
    logic [2:0]  rv;
    logic [10:0] raddr;
    logic        bsy;
  } vec_t;

  vec_t vecs [24];
  logic [2:0] hist [64];
  logic [2:0] exp_g;

  initial begin
    vecs[0]  = '{3'b000, J0, J1, J2,         3'b000, 1'b0, 11'h000, 3'b000, 11'h000, 1'b0};
    vecs[1]  = '{3'b010, J0, 11'h055, J2,    3'b010, 1'b0, 11'h000, 3'b000, 11'h000, 1'b1};
    vecs[2]  = '{3'b000, J0, J1, J2,         3'b000, 1'b1, 11'h055, 3'b000, 11'h000, 1'b1};
    vecs[3]  = '{3'b000, J0, J1, J2,         3'b000, 1'b0, 11'h055, 3'b000, 11'h000, 1'b1};
    vecs[4]  = '{3'b000, J0, J1, J2,         3'b000, 1'b0, 11'h055, 3'b000, 11'h000, 1'b1};
    vecs[5]  = '{3'b000, J0, J1, J2,         3'b000, 1'b0, 11'h055, 3'b010, 11'h055, 1'b1};
    vecs[6]  = '{3'b000, J0, J1, J2,         3'b000, 1'b0, 11'h055, 3'b000, 11'h000, 1'b0};
    vecs[7]  = '{3'b001, 11'h000, J1, J2,    3'b001, 1'b0, 11'h055, 3'b000, 11'h000, 1'b1};
    vecs[8]  = '{3'b010, J0, 11'h001, J2,    3'b010, 1'b1, 11'h000, 3'b000, 11'h000, 1'b1};
    vecs[9]  = '{3'b001, 11'h002, J1, J2,    3'b001, 1'b1, 11'h001, 3'b000, 11'h000, 1'b1};
    vecs[10] = '{3'b010, J0, 11'h003, J2,    3'b010, 1'b1, 11'h002, 3'b000, 11'h000, 1'b1};
    vecs[11] = '{3'b000, J0, J1, J2,         3'b000, 1'b1, 11'h003, 3'b001, 11'h000, 1'b1};
    vecs[12] = '{3'b000, J0, J1, J2,         3'b000, 1'b0, 11'h003, 3'b010, 11'h001, 1'b1};
    vecs[13] = '{3'b000, J0, J1, J2,         3'b000, 1'b0, 11'h003, 3'b001, 11'h002, 1'b1};
    vecs[14] = '{3'b000, J0, J1, J2,         3'b000, 1'b0, 11'h003, 3'b010, 11'h003, 1'b1};
    vecs[15] = '{3'b000, J0, J1, J2,         3'b000, 1'b0, 11'h003, 3'b000, 11'h000, 1'b0};
    vecs[16] = '{3'b100, J0, J1, 11'h123,    3'b100, 1'b0, 11'h003, 3'b000, 11'h000, 1'b1};
    vecs[17] = '{3'b011, 11'h010, 11'h011, J2, 3'b001, 1'b1, 11'h123, 3'b000, 11'h000, 1'b1};
    vecs[18] = '{3'b010, J0, 11'h011, J2,    3'b010, 1'b1, 11'h010, 3'b000, 11'h000, 1'b1};
    vecs[19] = '{3'b000, J0, J1, J2,         3'b000, 1'b1, 11'h011, 3'b000, 11'h000, 1'b1};
    vecs[20] = '{3'b000, J0, J1, J2,         3'b000, 1'b0, 11'h011, 3'b100, 11'h123, 1'b1};
    vecs[21] = '{3'b000, J0, J1, J2,         3'b000, 1'b0, 11'h011, 3'b001, 11'h010, 1'b1};
    vecs[22] = '{3'b000, J0, J1, J2,         3'b000, 1'b0, 11'h011, 3'b010, 11'h011, 1'b1};
    vecs[23] = '{3'b000, J0, J1, J2,         3'b000, 1'b0, 11'h011, 3'b000, 11'h000, 1'b0};

    do_reset();
    #1;
    chk("reset err", 512'(err_unexpected), 512'(1'b0));
    chk("reset resp_data", resp_data, '0);

    for (int i = 0; i < 24; i++) begin
      drive(vecs[i].req, vecs[i].a0, vecs[i].a1, vecs[i].a2);
      chk($sformatf("vec%0d req_aready", i), 512'(req_aready), 512'(vecs[i].rdy));
      chk($sformatf("vec%0d buf_avalid", i), 512'(buf_avalid), 512'(vecs[i].bav));
      chk($sformatf("vec%0d buf_addr", i),   512'(buf_addr),   512'(vecs[i].baddr));
      chk($sformatf("vec%0d resp_valid", i), 512'(resp_valid), 512'(vecs[i].rv));
      chk($sformatf("vec%0d busy", i),       512'(busy),       512'(vecs[i].bsy));
      if (vecs[i].rv != 3'b000)
        chk($sformatf("vec%0d resp_data", i), resp_data, dfun(vecs[i].raddr));
    end
    chk("table err", 512'(err_unexpected), 512'(1'b0));

    // Sticky hold: idle cycle must clear the hold count left by the first burst.
    do_reset();
    for (int i = 0; i < 10; i++) begin
      drive(3'b001, 11'h100, J1, 11'h300);
      chk($sformatf("pre%0d req_aready", i), 512'(req_aready), 512'(3'b001));
    end
    drive(3'b000, J0, J1, J2);
    for (int k = 0; k < 64; k++) begin
      drive(3'b101, 11'h100, J1, 11'h300);
      exp_g = (((k / 16) % 2) == 0) ? 3'b001 : 3'b100;
      hist[k] = exp_g;
      chk($sformatf("hold%0d req_aready", k), 512'(req_aready), 512'(exp_g));
      if (k == 0) begin
        chk("hold0 buf_avalid", 512'(buf_avalid), 512'(1'b0));
      end else begin
        chk($sformatf("hold%0d buf_avalid", k), 512'(buf_avalid), 512'(1'b1));
        chk($sformatf("hold%0d buf_addr", k), 512'(buf_addr),
            512'((hist[k-1] == 3'b001) ? 11'h100 : 11'h300));
      end
      if (k >= 4) begin
        chk($sformatf("hold%0d resp_valid", k), 512'(resp_valid), 512'(hist[k-4]));
        chk($sformatf("hold%0d resp_data", k), resp_data,
            dfun((hist[k-4] == 3'b001) ? 11'h100 : 11'h300));
      end
    end
    for (int i = 0; i < 6; i++) drive(3'b000, J0, J1, J2);
    chk("drain resp_valid", 512'(resp_valid), 512'(3'b000));
    chk("drain busy", 512'(busy), 512'(1'b0));
    chk("drain err", 512'(err_unexpected), 512'(1'b0));

    // Reset with two reads in flight, then a stray buffer return.
    do_reset();
    drive(3'b001, 11'h0AA, J1, J2);
    chk("mid acc0", 512'(req_aready), 512'(3'b001));
    drive(3'b010, J0, 11'h0BB, J2);
    chk("mid acc1", 512'(req_aready), 512'(3'b010));
    drive(3'b000, J0, J1, J2);
    chk("mid pre bav", 512'(buf_avalid), 512'(1'b1));
    chk("mid pre busy", 512'(busy), 512'(1'b1));
    areset = 1'b1;
    #1;
    chk("mid rst bav", 512'(buf_avalid), 512'(1'b0));
    chk("mid rst baddr", 512'(buf_addr), 512'(11'h000));
    chk("mid rst busy", 512'(busy), 512'(1'b0));
    chk("mid rst rv", 512'(resp_valid), 512'(3'b000));
    chk("mid rst rdata", resp_data, '0);
    chk("mid rst err", 512'(err_unexpected), 512'(1'b0));
    @(negedge aclk);
    areset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(3'b000, J0, J1, J2);
      chk($sformatf("post%0d rv", i), 512'(resp_valid), 512'(3'b000));
      chk($sformatf("post%0d err", i), 512'(err_unexpected), 512'(1'b0));
    end
    @(negedge aclk);
    stray = 1'b1;
    @(negedge aclk);
    stray = 1'b0;
    #1;
    chk("stray err", 512'(err_unexpected), 512'(1'b1));
    chk("stray rv", 512'(resp_valid), 512'(3'b000));
    drive(3'b000, J0, J1, J2);
    chk("stray err sticky", 512'(err_unexpected), 512'(1'b1));
    chk("stray rv2", 512'(resp_valid), 512'(3'b000));

`ifdef ARB_STATS_EN
    do_reset();
    #1;
    chk("stat reset", 512'(stat_grant_cnt), '0);
    for (int i = 0; i < 5; i++) drive(3'b001, 11'h001, J1, J2);
    for (int i = 0; i < 3; i++) drive(3'b100, J0, J1, 11'h002);
    drive(3'b000, J0, J1, J2);
    chk("stat cnt0", 512'(stat_grant_cnt[31:0]),  512'(32'd5));
    chk("stat cnt1", 512'(stat_grant_cnt[63:32]), 512'(32'd0));
    chk("stat cnt2", 512'(stat_grant_cnt[95:64]), 512'(32'd3));
    @(negedge aclk);
    stat_clr = 1'b1;
    req_avalid = 3'b001;
    @(negedge aclk);
    stat_clr = 1'b0;
    req_avalid = 3'b000;
    #1;
    chk("stat clr", 512'(stat_grant_cnt), '0);
    drive(3'b100, J0, J1, 11'h003);
    drive(3'b000, J0, J1, J2);
    chk("stat after clr", 512'(stat_grant_cnt), 512'({32'd1, 32'd0, 32'd0}));
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
